// File: rtl/fb_ctrl_pkg.sv
// Shared definitions for the frame buffer read and write controllers:
// FSM state encoding and default bus widths.
package fb_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } fb_state_e;

    localparam int FB_ADDR_WIDTH = 32;
    localparam int FB_DATA_WIDTH = 16;

endpackage

// File: rtl/fb_read_skid.sv
// One-deep skid stage between the 1-cycle-latency memory read return and the output FIFO.
// Holds {sof, eol, data} for a pixel that returns while the FIFO is full.
import fb_ctrl_pkg::*;

module fb_read_skid #(
    parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  pend,
    input  logic                  sof_i,
    input  logic                  eol_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  full_i,
    output logic                  fifo_wr_o,
    output logic [DATA_WIDTH-1:0] fifo_data_o,
    output logic                  fifo_sof_o,
    output logic                  fifo_eol_o,
    output logic                  skid_valid
);

    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_sof;
    logic                  skid_eol;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_sof   <= 1'b0;
            skid_eol   <= 1'b0;
        end else if (pend && full_i) begin
            skid_valid <= 1'b1;
            skid_data  <= rd_data_i;
            skid_sof   <= sof_i;
            skid_eol   <= eol_i;
        end else if (skid_valid && !full_i) begin
            skid_valid <= 1'b0;
        end
    end

    // pend and skid_valid are mutually exclusive, so the skid wins the mux only when it is holding.
    always_comb begin
        fifo_wr_o   = !full_i && (pend || skid_valid);
        fifo_data_o = '0;
        fifo_sof_o  = 1'b0;
        fifo_eol_o  = 1'b0;
        if (fifo_wr_o) begin
            fifo_data_o = skid_valid ? skid_data : rd_data_i;
            fifo_sof_o  = skid_valid ? skid_sof  : sof_i;
            fifo_eol_o  = skid_valid ? skid_eol  : eol_i;
        end
    end

endmodule

// File: rtl/control_frame_buffer_read.sv
// Frame buffer read controller: sweeps BASE_ADDR + 0..W*D-1 frame after frame into the output FIFO.
// Define FB_READ_SOF_EOL_EN to generate start-of-frame / end-of-line pixel tags.
import fb_ctrl_pkg::*;

module control_frame_buffer_read #(
    parameter int                    ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = FB_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [15:0]           resolution_width_i,
    input  logic [15:0]           resolution_depth_i,
    input  logic                  page_written_once_i,
    output logic                  rd_o,
    output logic [ADDR_WIDTH-1:0] addr_rd_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  full_i,
    output logic                  fifo_wr_o,
    output logic [DATA_WIDTH-1:0] fifo_data_o,
    output logic                  frame_done_o,
    output logic                  sof_o,
    output logic                  eol_o
);

    fb_state_e             state, state_nxt;
    logic [15:0]           w_lat, d_lat;
    logic [ADDR_WIDTH-1:0] pix_cnt;
    logic [31:0]           frame_size;
    logic                  start, issue, last_pix;
    logic                  pend, skid_valid;
    logic                  sof_pend, eol_pend;

    assign start      = page_written_once_i && (resolution_width_i != 16'd0) && (resolution_depth_i != 16'd0);
    assign frame_size = {16'd0, w_lat} * {16'd0, d_lat};
    assign last_pix   = (pix_cnt == ADDR_WIDTH'(frame_size - 32'd1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // READ is only left through reset; the writer's flag dropping later is ignored.
    always_comb begin
        state_nxt = state;
        if (state == ST_IDLE && start) state_nxt = ST_READ;
    end

    always_comb begin
        issue     = (state == ST_READ) && !full_i && !skid_valid;
        rd_o      = issue;
        addr_rd_o = BASE_ADDR + pix_cnt;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pix_cnt      <= '0;
            w_lat        <= '0;
            d_lat        <= '0;
            pend         <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            pend         <= issue;
            frame_done_o <= 1'b0;
            if (state == ST_IDLE && start) begin
                w_lat <= resolution_width_i;
                d_lat <= resolution_depth_i;
            end
            if (issue) begin
                if (last_pix) begin
                    pix_cnt      <= '0;
                    frame_done_o <= 1'b1;
                    w_lat        <= resolution_width_i;
                    d_lat        <= resolution_depth_i;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
        end
    end

`ifdef FB_READ_SOF_EOL_EN
    logic [15:0] x_cnt;

    // Tags are computed at issue and ride alongside the returning data.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            x_cnt    <= '0;
            sof_pend <= 1'b0;
            eol_pend <= 1'b0;
        end else begin
            if (issue) begin
                sof_pend <= (pix_cnt == '0);
                eol_pend <= (x_cnt == w_lat - 16'd1);
                x_cnt    <= (last_pix || x_cnt == w_lat - 16'd1) ? 16'd0 : x_cnt + 16'd1;
            end else begin
                sof_pend <= 1'b0;
                eol_pend <= 1'b0;
            end
        end
    end
`else
    assign sof_pend = 1'b0;
    assign eol_pend = 1'b0;
`endif

    fb_read_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .pend        (pend),
        .sof_i       (sof_pend),
        .eol_i       (eol_pend),
        .rd_data_i   (rd_data_i),
        .full_i      (full_i),
        .fifo_wr_o   (fifo_wr_o),
        .fifo_data_o (fifo_data_o),
        .fifo_sof_o  (sof_o),
        .fifo_eol_o  (eol_o),
        .skid_valid  (skid_valid)
    );

endmodule

// File: tb/tb_control_frame_buffer_read.sv
// Self-checking bench for control_frame_buffer_read (W=10, D=4, memory returns data = address).
module tb_control_frame_buffer_read;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] resolution_width_i = 16'd10;
    logic [15:0] resolution_depth_i = 16'd4;
    logic        page_written_once_i;
    logic        rd_o;
    logic [31:0] addr_rd_o;
    logic [15:0] rd_data_i;
    logic        full_i;
    logic        fifo_wr_o;
    logic [15:0] fifo_data_o;
    logic        frame_done_o;
    logic        sof_o, eol_o;

    control_frame_buffer_read dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .resolution_width_i  (resolution_width_i),
        .resolution_depth_i  (resolution_depth_i),
        .page_written_once_i (page_written_once_i),
        .rd_o                (rd_o),
        .addr_rd_o           (addr_rd_o),
        .rd_data_i           (rd_data_i),
        .full_i              (full_i),
        .fifo_wr_o           (fifo_wr_o),
        .fifo_data_o         (fifo_data_o),
        .frame_done_o        (frame_done_o),
        .sof_o               (sof_o),
        .eol_o               (eol_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous memory with one cycle of latency; contents equal the address.
    always @(posedge clk_i) rd_data_i <= addr_rd_o[15:0];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: pixel indices pushed at issue, popped at FIFO push.
    int  sb_q[$];
    int  exp_addr   = 0;
    bit  fd_pend    = 1'b0;
    int  pushes     = 0;
    bit  mon_en     = 1'b0;
    bit  stream_chk = 1'b0;

    always @(negedge clk_i) begin
        int v;
        if (reset_i) begin
            exp_addr = 0;
            fd_pend  = 1'b0;
            sb_q.delete();
        end else if (mon_en) begin
            check("frame_done", frame_done_o, fd_pend);
            fd_pend = 1'b0;
            if (stream_chk) check("gapless_rd", rd_o, 1);
            if (rd_o) begin
                check("addr", addr_rd_o, exp_addr);
                sb_q.push_back(exp_addr);
                if (exp_addr == 39) fd_pend = 1'b1;
                exp_addr = (exp_addr + 1) % 40;
            end
            if (fifo_wr_o) begin
                check("push_while_full", full_i, 0);
                if (sb_q.size() == 0) begin
                    check("unexpected_push", 1, 0);
                end else begin
                    v = sb_q.pop_front();
                    check("data", fifo_data_o, v);
`ifdef FB_READ_SOF_EOL_EN
                    check("sof", sof_o, (v == 0) ? 1 : 0);
                    check("eol", eol_o, (v % 10 == 9) ? 1 : 0);
`else
                    check("sof", sof_o, 0);
                    check("eol", eol_o, 0);
`endif
                end
                pushes++;
            end
            if (stream_chk) check("latency", sb_q.size(), 1);
        end
    end

    task automatic wait_issue(input int target);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(rd_o && addr_rd_o == target) && n < 500);
        check("wait_issue", (rd_o && addr_rd_o == target) ? 1 : 0, 1);
    endtask

    task automatic wait_pushes(input int target);
        int n = 0;
        while (pushes < target && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        check("wait_pushes", (pushes >= target) ? 1 : 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"},   rd_o, 0);
        check({tag, "_addr"}, addr_rd_o, 0);
        check({tag, "_wr"},   fifo_wr_o, 0);
        check({tag, "_data"}, fifo_data_o, 0);
        check({tag, "_fd"},   frame_done_o, 0);
        check({tag, "_tags"}, {sof_o, eol_o}, 0);
    endtask

    initial begin
        int target, n;
        reset_i             = 1'b1;
        page_written_once_i = 1'b0;
        full_i              = 1'b0;

        // Reset and idle without a written page
        repeat (3) begin
            @(negedge clk_i);
            check_all_zero("reset");
        end
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        mon_en  = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            check("idle_rd", rd_o, 0);
        end

        // Free-running sweep: one pixel per cycle across a frame wrap
        @(posedge clk_i); #1;
        page_written_once_i = 1'b1;
        @(posedge clk_i); #1;
        stream_chk = 1'b1;
        wait_pushes(40);
        page_written_once_i = 1'b0;
        wait_issue(5);

        // FIFO full right after pixel 5 is issued
        @(posedge clk_i); #1;
        stream_chk = 1'b0;
        full_i     = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            check("stall_rd", rd_o, 0);
            check("stall_wr", fifo_wr_o, 0);
        end
        @(posedge clk_i); #1;
        full_i = 1'b0;
        @(negedge clk_i);
        check("drain_rd", rd_o, 0);
        check("drain_wr", fifo_wr_o, 1);
        check("drain_data", fifo_data_o, 5);
        @(negedge clk_i);
        check("resume_rd", rd_o, 1);
        check("resume_addr", addr_rd_o, 6);
        check("resume_wr", fifo_wr_o, 0);

        // Random back-pressure over three whole frames
        wait_pushes(80);
        target = 80 + 3 * 40;
        n = 0;
        while (pushes < target && n < 3000) begin
            @(posedge clk_i); #1;
            full_i = 1'($urandom_range(0, 1));
            n++;
        end
        check("random_pushes", pushes, target);
        @(posedge clk_i); #1;
        full_i = 1'b0;

        // Reset in the middle of a frame
        wait_issue(17);
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        #1;
        check_all_zero("mid_reset");
        page_written_once_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!rd_o && n < 20);
        check("restart_rd", rd_o, 1);
        check("restart_addr", addr_rd_o, 0);
        target = pushes + 40;
        wait_pushes(target);
        repeat (3) @(negedge clk_i);
        check("sb_drained", sb_q.size() <= 1 ? 1 : 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
